control_sequencer: RTL

Micro-sequencer that drives the register load strobes and bus-source enables of the NSC-8 datapath. It decides, cycle by cycle, which register writes from the shared bus, including the `load_b` and `load_immediate_b` strobes consumed by the B register. It steps a 5-state T-counter through fetch and execute for each instruction, supports free-run and single-step modes, and halts on `HLT`.

---
 rtl/control_sequencer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// Micro-sequencer for the NSC-8 datapath: a five-state T-counter that Moore-decodes
// the bus-source enables and register load strobes, with free-run, single-step and HLT.
module control_sequencer #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] instr,
  input  logic         run,
  input  logic         step,
  output logic         pc_out,
  output logic         ram_out,
  output logic         ir_out,
  output logic         a_out,
  output logic         alu_out,
  output logic         pc_inc,
  output logic         mar_load,
  output logic         ir_load,
  output logic         load_a,
  output logic         load_b,
  output logic         load_immediate_b,
  output logic         out_load,
  output logic         alu_sub,
  output logic         halted,
  output logic [2:0]   t_state
);

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDA  = 4'h1,
    OP_LDB  = 4'h2,
    OP_LDIB = 4'h3,
    OP_ADD  = 4'h4,
    OP_SUB  = 4'h5,
    OP_OUT  = 4'h6,
    OP_HLT  = 4'hF
  } opcode_t;

  state_t     state, next_state;
  logic       halt_q, halt_next;
  logic       pending, pending_next;
  logic       step_prev;
  logic       step_edge;
  logic       advance;
  logic [3:0] opcode;
  logic       unused_operand;

  assign opcode         = instr[N-1:N/2];
  assign unused_operand = ^instr[N/2-1:0];
  assign step_edge      = step & ~step_prev;
  assign advance        = (state == T0) && (run || pending) && !halt_q;

  // NOTE: synchronous reset clears every state bit; all sequential updates use <=.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= T0;
      halt_q    <= 1'b0;
      pending   <= 1'b0;
      step_prev <= 1'b0;
    end else begin
      state     <= next_state;
      halt_q    <= halt_next;
      pending   <= pending_next;
      step_prev <= step;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    halt_next  = halt_q;
    if (!halt_q) begin
      case (state)
        T0: if (advance) next_state = T1;
        T1: next_state = T2;
        T2: begin
          if (opcode == OP_HLT) halt_next = 1'b1;
          else                  next_state = T3;
        end
        T3: next_state = T4;
        default: next_state = T0;
      endcase
    end
  end

  // A single request is remembered; a new edge in the consuming cycle survives it.
  always_comb begin
    pending_next = pending;
    if (run || halt_q)  pending_next = 1'b0;
    else if (step_edge) pending_next = 1'b1;
    else if (advance)   pending_next = 1'b0;
  end

  always_comb begin
    pc_out           = 1'b0;
    ram_out          = 1'b0;
    ir_out           = 1'b0;
    a_out            = 1'b0;
    alu_out          = 1'b0;
    pc_inc           = 1'b0;
    mar_load         = 1'b0;
    ir_load          = 1'b0;
    load_a           = 1'b0;
    load_b           = 1'b0;
    load_immediate_b = 1'b0;
    out_load         = 1'b0;
    alu_sub          = 1'b0;
    halted           = halt_q;
    if (!halt_q) begin
      case (state)
        T0: begin
          pc_out   = 1'b1;
          mar_load = 1'b1;
        end
        T1: begin
          ram_out = 1'b1;
          ir_load = 1'b1;
          pc_inc  = 1'b1;
        end
        T2: begin
          case (opcode)
            OP_LDA, OP_LDB: begin
              ir_out   = 1'b1;
              mar_load = 1'b1;
            end
            OP_LDIB: begin
              ir_out           = 1'b1;
              load_immediate_b = 1'b1;
            end
            OP_ADD: begin
              alu_out = 1'b1;
              load_a  = 1'b1;
            end
            OP_SUB: begin
              alu_out = 1'b1;
              alu_sub = 1'b1;
              load_a  = 1'b1;
            end
            OP_OUT: begin
              a_out    = 1'b1;
              out_load = 1'b1;
            end
            default: ;
          endcase
        end
        T3: begin
          if (opcode == OP_LDA) begin
            ram_out = 1'b1;
            load_a  = 1'b1;
          end else if (opcode == OP_LDB) begin
            ram_out = 1'b1;
            load_b  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign t_state = state;

endmodule
